// File: rtl/descriptor_window_hold.sv
// ROWS x COLS sliding gradient window for the SIFT descriptor path.
// Each accepted column shifts the window; line starts apply zero-fill or replicate border.
module descriptor_window_hold #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned ROWS        = 16,
    parameter int unsigned COLS        = 16,
    parameter int unsigned BORDER_MODE = 0,
    parameter int unsigned CNT_BITS    = 5
) (
    input  logic                           iclk,
    input  logic                           ireset,
    input  logic                           iflush,
    input  logic                           ivalid,
    input  logic                           iline_start,
    input  logic [ROWS*DATA_BITS-1:0]      igradient,
    output logic [ROWS*COLS*DATA_BITS-1:0] ogradient,
    output logic                           ovalid,
    output logic [CNT_BITS-1:0]            ofill_count
);

    localparam int unsigned WIN_BITS = ROWS * COLS * DATA_BITS;
    localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(COLS);
    localparam logic [CNT_BITS-1:0] ONE  = CNT_BITS'(1);

    logic [WIN_BITS-1:0] win_next;
    logic [CNT_BITS-1:0] cnt_next;
    logic                valid_next;

    // Next window, fill count and valid for an accepted beat; hold otherwise.
    always_comb begin
        win_next   = ogradient;
        cnt_next   = ofill_count;
        valid_next = 1'b0;
        if (ivalid) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned c = 1; c < COLS; c++) begin
                    if (iline_start) begin
                        win_next[(r*COLS+c)*DATA_BITS +: DATA_BITS] =
                            (BORDER_MODE == 1) ? igradient[r*DATA_BITS +: DATA_BITS]
                                               : {DATA_BITS{1'b0}};
                    end else begin
                        win_next[(r*COLS+c)*DATA_BITS +: DATA_BITS] =
                            ogradient[(r*COLS+c-1)*DATA_BITS +: DATA_BITS];
                    end
                end
                win_next[(r*COLS)*DATA_BITS +: DATA_BITS] = igradient[r*DATA_BITS +: DATA_BITS];
            end
            if (iline_start) begin
                cnt_next = (BORDER_MODE == 1) ? FULL : ONE;
            end else if (ofill_count != FULL) begin
                cnt_next = ofill_count + ONE;
            end
            valid_next = (cnt_next == FULL);
        end
    end

    // Flush behaves exactly like reset and discards any same-cycle beat.
    always_ff @(posedge iclk) begin
        if (ireset || iflush) begin
            ogradient   <= '0;
            ofill_count <= '0;
            ovalid      <= 1'b0;
        end else begin
            ogradient   <= win_next;
            ofill_count <= cnt_next;
            ovalid      <= valid_next;
        end
    end

endmodule

// File: tb/tb_descriptor_window_hold.sv
// Scoreboard bench: zero-fill and replicate instances share stimulus; monitor pops expectations.
module tb_descriptor_window_hold;

    localparam int unsigned DB = 8;
    localparam int unsigned R  = 4;
    localparam int unsigned C  = 4;
    localparam int unsigned CB = 5;

    typedef logic [R*C*DB-1:0] win_t;
    typedef logic [R*DB-1:0]   col_t;
    typedef logic [CB-1:0]     cnt_t;

    typedef struct packed {
        win_t w0; cnt_t n0; logic v0;
        win_t w1; cnt_t n1; logic v1;
    } exp_t;

    logic clk;
    logic ireset, iflush, ivalid, iline_start;
    col_t igradient;
    win_t grad0, grad1;
    logic vld0, vld1;
    cnt_t cnt0, cnt1;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    win_t mw0 = '0, mw1 = '0;
    cnt_t mn0 = '0, mn1 = '0;

    descriptor_window_hold #(.DATA_BITS(DB), .ROWS(R), .COLS(C), .BORDER_MODE(0), .CNT_BITS(CB)) u0 (
        .iclk(clk), .ireset(ireset), .iflush(iflush), .ivalid(ivalid), .iline_start(iline_start),
        .igradient(igradient), .ogradient(grad0), .ovalid(vld0), .ofill_count(cnt0));

    descriptor_window_hold #(.DATA_BITS(DB), .ROWS(R), .COLS(C), .BORDER_MODE(1), .CNT_BITS(CB)) u1 (
        .iclk(clk), .ireset(ireset), .iflush(iflush), .ivalid(ivalid), .iline_start(iline_start),
        .igradient(igradient), .ogradient(grad1), .ovalid(vld1), .ofill_count(cnt1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input win_t got, input win_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [DB-1:0] el(input win_t w, input int r, input int c);
        return w[(r*C+c)*DB +: DB];
    endfunction

    function automatic col_t ramp(input int k);
        col_t col;
        for (int r = 0; r < R; r++) col[r*DB +: DB] = DB'(r*16 + k);
        return col;
    endfunction

    function automatic col_t splat(input logic [DB-1:0] v);
        col_t col;
        for (int r = 0; r < R; r++) col[r*DB +: DB] = v;
        return col;
    endfunction

    // Reference behaviour of one instance for one clock edge.
    task automatic model(input int mode, input logic rst, input logic fl, input logic v,
                         input logic ls, input col_t col,
                         inout win_t w, inout cnt_t n, output logic ov);
        ov = 1'b0;
        if (rst || fl) begin
            w = '0;
            n = '0;
        end else if (v) begin
            for (int r = 0; r < R; r++) begin
                for (int c = C - 1; c >= 1; c--) begin
                    if (ls) w[(r*C+c)*DB +: DB] = (mode == 1) ? col[r*DB +: DB] : '0;
                    else    w[(r*C+c)*DB +: DB] = w[(r*C+c-1)*DB +: DB];
                end
                w[(r*C)*DB +: DB] = col[r*DB +: DB];
            end
            if (ls) n = (mode == 1) ? CB'(C) : CB'(1);
            else if (n != CB'(C)) n = n + CB'(1);
            ov = (n == CB'(C));
        end
    endtask

    task automatic step(input logic rst, input logic fl, input logic v, input logic ls, input col_t col);
        exp_t e;
        logic o0, o1;
        @(negedge clk);
        ireset = rst; iflush = fl; ivalid = v; iline_start = ls; igradient = col;
        model(0, rst, fl, v, ls, col, mw0, mn0, o0);
        model(1, rst, fl, v, ls, col, mw1, mn1, o1);
        e.w0 = mw0; e.n0 = mn0; e.v0 = o0;
        e.w1 = mw1; e.n1 = mn1; e.v1 = o1;
        q.push_back(e);
    endtask

    task automatic beat(input col_t col);
        step(1'b0, 1'b0, 1'b1, 1'b0, col);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every clock edge that follows issued stimulus has one expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("m0_window", grad0, e.w0);
                cmp("m0_count", win_t'(cnt0), win_t'(e.n0));
                cmp("m0_valid", win_t'(vld0), win_t'(e.v0));
                cmp("m1_window", grad1, e.w1);
                cmp("m1_count", win_t'(cnt1), win_t'(e.n1));
                cmp("m1_valid", win_t'(vld1), win_t'(e.v1));
            end
        end
    end

    initial begin
        ireset = 1'b0; iflush = 1'b0; ivalid = 1'b0; iline_start = 1'b0; igradient = '0;

        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        settle();
        cmp("reset_count", win_t'(cnt0), win_t'(0));

        // Fill with ramp columns 1..4
        for (int k = 1; k <= 4; k++) beat(ramp(k));
        settle();
        cmp("t1_valid", win_t'(vld0), win_t'(1));
        cmp("t1_e21", win_t'(el(grad0, 2, 1)), win_t'(8'h23));
        cmp("t1_e03", win_t'(el(grad0, 0, 3)), win_t'(8'h01));

        // Gap cycle, then beat 5
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        settle();
        cmp("t2_gap_valid", win_t'(vld0), win_t'(0));
        cmp("t2_gap_e00", win_t'(el(grad0, 0, 0)), win_t'(8'h04));
        beat(ramp(5));
        settle();
        cmp("t2_e00", win_t'(el(grad0, 0, 0)), win_t'(8'h05));
        cmp("t2_e33", win_t'(el(grad0, 3, 3)), win_t'(8'h32));
        cmp("t2_count", win_t'(cnt0), win_t'(4));

        // Line start without valid is ignored
        step(1'b0, 1'b0, 1'b0, 1'b1, splat(8'h11));
        settle();
        cmp("ls_novalid_e10", win_t'(el(grad0, 1, 0)), win_t'(8'h15));

        // Zero-fill line start, then three more beats to refill
        step(1'b0, 1'b0, 1'b1, 1'b1, splat(8'hAA));
        settle();
        cmp("t3_count", win_t'(cnt0), win_t'(1));
        cmp("t3_valid", win_t'(vld0), win_t'(0));
        cmp("t3_e23", win_t'(el(grad0, 2, 3)), win_t'(0));
        cmp("t3_rep_e13", win_t'(el(grad1, 1, 3)), win_t'(8'hAA));
        beat(ramp(6));
        beat(ramp(7));
        settle();
        cmp("t3_not_yet", win_t'(vld0), win_t'(0));
        beat(ramp(8));
        settle();
        cmp("t3_refilled", win_t'(vld0), win_t'(1));

        // Replicate line start
        step(1'b0, 1'b0, 1'b1, 1'b1, splat(8'h5C));
        settle();
        cmp("t4_e32", win_t'(el(grad1, 3, 2)), win_t'(8'h5C));
        cmp("t4_count", win_t'(cnt1), win_t'(4));
        cmp("t4_valid", win_t'(vld1), win_t'(1));

        // Flush with a same-cycle beat
        for (int k = 1; k <= 4; k++) beat(ramp(k));
        step(1'b0, 1'b1, 1'b1, 1'b0, splat(8'hFF));
        settle();
        cmp("t5_window", grad0, '0);
        cmp("t5_count", win_t'(cnt0), win_t'(0));

        // Mid-stream reset, then one beat
        for (int k = 1; k <= 4; k++) beat(ramp(k));
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        beat(ramp(9));
        settle();
        cmp("t6_count", win_t'(cnt0), win_t'(1));
        cmp("t6_e00", win_t'(el(grad0, 0, 0)), win_t'(8'h09));
        cmp("t6_e01", win_t'(el(grad0, 0, 1)), win_t'(0));
        cmp("t6_valid", win_t'(vld1), win_t'(0));

        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/descriptor_window_hold.md
Name: descriptor_window_hold

Overview:
- Parametrised ROWS x COLS sliding-window register array for the SIFT descriptor path.
- Sits between the gradient line buffers and the descriptor histogram stage.
- Each accepted input beat is one column of ROWS gradients. The beat shifts the window one column and publishes the whole window in parallel.
- Adds over the fixed-size hold stage: a valid qualifier, a fill tracker, line-start border handling (zero-fill or replicate), and flush.

Parameters:
DATA_BITS, 8, width of one gradient element
ROWS, 16, window height = gradients per input column
COLS, 16, window width = shift depth per row
BORDER_MODE, 0, line-start fill: 0 = zero-fill, 1 = replicate first column
CNT_BITS, 5, fill-counter width; must satisfy 2^CNT_BITS > COLS

Ports:
iclk  input  1  clock; all state updates on rising edge
ireset  input  1  synchronous, active-high reset
iflush  input  1  clear window and fill state (synchronous)
ivalid  input  1  igradient carries a valid column this cycle
iline_start  input  1  qualifies ivalid: this column is the first of a new image line
igradient  input  ROWS*DATA_BITS  input column; row r at [r*DATA_BITS +: DATA_BITS]
ogradient  output  ROWS*COLS*DATA_BITS  window; element (r,c) at [(r*COLS+c)*DATA_BITS +: DATA_BITS]; c=0 is newest column
ovalid  output  1  window fully populated and updated last cycle
ofill_count  output  CNT_BITS  valid columns currently held, 0..COLS, saturating

Behaviour:
- All registers are updated only on the rising edge of iclk.
- Priority each cycle: ireset > iflush > (ivalid & iline_start) > ivalid > hold.
- Reset/flush:
  - every window element = 0, ofill_count = 0, ovalid = 0.
  - iflush has identical effect to ireset; any ivalid in the same cycle is discarded.
- Normal shift (ivalid=1, iline_start=0):
  - for every row r: W[r][0] <= igradient row r; W[r][c] <= W[r][c-1] for c = 1..COLS-1.
  - the oldest column is dropped.
  - ofill_count <= min(ofill_count+1, COLS).
- Line start (ivalid=1, iline_start=1):
  - W[r][0] <= igradient row r.
  - BORDER_MODE=0: W[r][c] <= 0 for c >= 1; ofill_count <= 1.
  - BORDER_MODE=1: W[r][c] <= igradient row r for all c; ofill_count <= COLS.
- Hold (ivalid=0): window and ofill_count unchanged; ovalid <= 0.
- iline_start with ivalid=0 is ignored.
- ovalid is registered. It is high for exactly one cycle after each accepted beat whose resulting fill count equals COLS, otherwise low.
  - latency: input column visible on ogradient c=0 one cycle after acceptance.
  - ovalid and the ogradient update occur in the same cycle.
- Saturation: ofill_count never exceeds COLS. Continuous ivalid after fill produces ovalid on every cycle.
- Element values are stored unmodified: no sign extension or arithmetic. Width is exactly DATA_BITS per element.
- COLS=1 is legal: window = input register; ovalid follows every accepted beat.
- Mid-stream reset or flush: the next accepted beat starts from count 0 (or from the line-start rule if iline_start=1). No stale data appears on ogradient.

Test Plan:
1. ROWS=COLS=4, DATA_BITS=8, mode 0; reset, then ivalid beats with columns {r*16+k} for k=1..4 -> ovalid first high one cycle after beat 4. Element (r,c) = r*16+(4-c); ofill_count goes 1,2,3,4.
2. Same config, continue beat 5 with a 1-cycle ivalid gap before it -> ovalid low in the gap cycle with window unchanged. After beat 5: column 0 = r*16+5, beat 1 gone, ofill_count stays 4, ovalid high.
3. Mode 0, iline_start with column 0xAA after a full window -> c0 = 0xAA, c1..c3 = 0, ofill_count = 1, ovalid = 0. Three more beats are needed before ovalid rises.
4. Mode 1, iline_start with column 0x5C -> all 4 columns = 0x5C, ofill_count = 4, ovalid = 1 next cycle.
5. Full window, then assert iflush together with ivalid carrying 0xFF -> all elements 0, ofill_count 0, ovalid 0; the 0xFF beat is discarded.
6. ireset asserted for one cycle mid-stream (window full) -> same outputs as the flush case. The next beat gives ofill_count = 1 with only column 0 non-zero.
